// File: rtl/f2m_sqr_iter.sv
// f2m_sqr_iter: repeated squaring z = a^(2^k) mod f(x) over F_{2^m}.
// Applies up to S squarings per clock through an unrolled chain.
// Ports:
//   clk, rst      rising-edge clock, async active-high reset
//   start         request pulse, only sampled while idle
//   a [M-1:0]     operand, captured on an accepted start
//   k [CW-1:0]    number of squarings, captured on an accepted start
//   busy          high while an operation is running
//   done          one-cycle pulse when z is updated
//   z [M-1:0]     result, held until the next completion
module f2m_sqr_iter #(
   parameter int M = 163,
   parameter logic [M-1:0] FX = 'hc9,
   parameter int S = 1,
   parameter int CW = 9
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [M-1:0]  a,
   input  logic [CW-1:0] k,
   output logic          busy,
   output logic          done,
   output logic [M-1:0]  z
);

   typedef enum logic {IDLE, RUN} state_t;
   typedef logic [M-2:0][M-1:0] red_t;

   // Row i holds x^(M+i) mod f(x); each row is x times the previous one.
   function automatic red_t red_tab();
      red_t t;
      logic [M-1:0] r;
      t = '0;
      r = FX;
      for (int i = 0; i < M-1; i++) begin
         t[i] = r;
         if (r[M-1])
            r = {r[M-2:0], 1'b0} ^ FX;
         else
            r = {r[M-2:0], 1'b0};
      end
      return t;
   endfunction

   localparam red_t RED = red_tab();

   // Squaring in GF(2) spreads bit i to bit 2i; the high half is folded
   // back with the precomputed reduction rows.
   function automatic logic [M-1:0] sq(input logic [M-1:0] v);
      logic [2*M-2:0] w;
      logic [M-1:0] r;
      w = '0;
      for (int i = 0; i < M; i++)
         w[2*i] = v[i];
      r = w[M-1:0];
      for (int i = 0; i < M-1; i++)
         if (w[M+i])
            r = r ^ RED[i];
      return r;
   endfunction

   state_t        state;
   logic [M-1:0]  acc;
   logic [CW-1:0] rem;
   logic [M-1:0]  chain [S+1];
   logic [M-1:0]  fin;

   always_comb begin
      chain[0] = acc;
      for (int j = 1; j <= S; j++)
         chain[j] = sq(chain[j-1]);
   end

   // Final step applies only the remaining rem (<= S) squarings.
   always_comb begin
      fin = chain[S];
      for (int j = 1; j < S; j++)
         if (rem == CW'(j))
            fin = chain[j];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         z     <= '0;
         acc   <= '0;
         rem   <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  if (k == '0) begin
                     z    <= a;
                     done <= 1'b1;
                  end else begin
                     acc   <= a;
                     rem   <= k;
                     state <= RUN;
                     busy  <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (rem > CW'(S)) begin
                  acc <= chain[S];
                  rem <= rem - CW'(S);
               end else begin
                  z     <= fin;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
